// File: rtl/serdes_lb_pkg.sv
// Shared definitions for the SerDes loopback checker: 8b/10b K-code values,
// the default expected loopback word, and the checker FSM state encoding.
package serdes_lb_pkg;

   // K-code byte values: Kx.y = {y[2:0], x[4:0]}
   localparam logic [7:0] K28_0 = 8'h1C;
   localparam logic [7:0] K28_1 = 8'h3C;
   localparam logic [7:0] K28_2 = 8'h5C;
   localparam logic [7:0] K28_3 = 8'h7C;
   localparam logic [7:0] K28_4 = 8'h9C;
   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K28_6 = 8'hDC;
   localparam logic [7:0] K28_7 = 8'hFC;
   localparam logic [7:0] K23_7 = 8'hF7;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K30_7 = 8'hFE;

   // Comma in byte 0, 16'hCAFE marker above it, rest zero.
   localparam logic [63:0] DEF_EXP_DATA = {40'h0, 16'hCAFE, K28_5};
   localparam logic [7:0]  DEF_EXP_K    = 8'h01;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } lb_state_e;

endpackage

// File: rtl/serdes_lb_satcnt.sv
// Saturating up-counter with a synchronous clear that beats increment.
module serdes_lb_satcnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/serdes_lb_checker.sv
// Loopback word checker: hunts for a run of expected words, reports lock,
// and counts mismatches while locked plus 8b/10b code/disparity errors.
module serdes_lb_checker
   import serdes_lb_pkg::*;
#(
   parameter logic [63:0] EXP_DATA   = DEF_EXP_DATA,
   parameter logic [7:0]  EXP_K      = DEF_EXP_K,
   parameter int          LOCK_CNT   = 8,
   parameter int          UNLOCK_CNT = 4,
   parameter int          CNT_W      = 16
) (
   input  logic             rx_clk_i,
   input  logic             trx_rst_i,
   input  logic             rx_reset_done_i,
   input  logic [63:0]      rx_data_i,
   input  logic [7:0]       rx_char_is_k_i,
   input  logic [7:0]       rx_not_in_table_i,
   input  logic [7:0]       rx_disp_err_i,
   input  logic             err_clr_i,
   output logic             locked_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [CNT_W-1:0] code_err_cnt_o
);

   localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
   localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_CNT - 1);

   lb_state_e  state_q, state_d;
   logic [7:0] run_q, run_d;
   logic       locked_q, locked_d;
   logic       err_q, err_d;
   logic       code_err_inc;
   logic       word_code_err;
   logic       word_good;

   assign word_code_err = (|rx_not_in_table_i) | (|rx_disp_err_i);
   assign word_good     = (rx_data_i == EXP_DATA) && (rx_char_is_k_i == EXP_K)
                          && !word_code_err;

   always_comb begin
      state_d      = state_q;
      run_d        = run_q;
      err_d        = 1'b0;
      code_err_inc = word_code_err && (state_q != ST_WAIT);

      // Bad words seen in LOCKED are reported even if reset-done drops with them.
      if (state_q == ST_LOCKED && !word_good) begin
         err_d = 1'b1;
      end

      if (!rx_reset_done_i) begin
         state_d = ST_WAIT;
         run_d   = '0;
      end else begin
         case (state_q)
            ST_WAIT: begin
               state_d = ST_HUNT;
               run_d   = '0;
            end
            ST_HUNT: begin
               if (!word_good) begin
                  run_d = '0;
               end else if (run_q == LOCK_LAST) begin
                  state_d = ST_LOCKED;
                  run_d   = '0;
               end else begin
                  run_d = run_q + 8'd1;
               end
            end
            ST_LOCKED: begin
               if (word_good) begin
                  run_d = '0;
               end else if (run_q == UNLOCK_LAST) begin
                  state_d = ST_HUNT;
                  run_d   = '0;
               end else begin
                  run_d = run_q + 8'd1;
               end
            end
            default: begin
               state_d = ST_WAIT;
               run_d   = '0;
            end
         endcase
      end

      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge rx_clk_i) begin
      if (trx_rst_i) begin
         state_q  <= ST_WAIT;
         run_q    <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   serdes_lb_satcnt #(.W(CNT_W)) u_err_cnt (
      .clk   (rx_clk_i),
      .srst  (trx_rst_i),
      .clr   (err_clr_i),
      .inc   (err_d),
      .cnt_o (err_cnt_o)
   );

   serdes_lb_satcnt #(.W(CNT_W)) u_code_err_cnt (
      .clk   (rx_clk_i),
      .srst  (trx_rst_i),
      .clr   (err_clr_i),
      .inc   (code_err_inc),
      .cnt_o (code_err_cnt_o)
   );

   assign locked_o = locked_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_serdes_lb_checker.sv
// Directed bench for serdes_lb_checker with 4-bit counters so saturation is reachable.
module tb_serdes_lb_checker;
   import serdes_lb_pkg::*;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             trx_rst;
   logic             rx_reset_done;
   logic [63:0]      rx_data;
   logic [7:0]       rx_char_is_k;
   logic [7:0]       rx_not_in_table;
   logic [7:0]       rx_disp_err;
   logic             err_clr;
   logic             locked;
   logic             err;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] code_err_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int exp_err   = 0;

   serdes_lb_checker #(.CNT_W(CNT_W)) dut (
      .rx_clk_i          (clk),
      .trx_rst_i         (trx_rst),
      .rx_reset_done_i   (rx_reset_done),
      .rx_data_i         (rx_data),
      .rx_char_is_k_i    (rx_char_is_k),
      .rx_not_in_table_i (rx_not_in_table),
      .rx_disp_err_i     (rx_disp_err),
      .err_clr_i         (err_clr),
      .locked_o          (locked),
      .err_o             (err),
      .err_cnt_o         (err_cnt),
      .code_err_cnt_o    (code_err_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic good_word();
      rx_data         = 64'h0000_0000_00CA_FEBC;
      rx_char_is_k    = 8'h01;
      rx_not_in_table = 8'h00;
      rx_disp_err     = 8'h00;
   endtask

   task automatic bad_word();
      good_word();
      rx_data = 64'h0;
   endtask

   task automatic relock();
      for (int i = 0; i < 8; i++) begin
         good_word();
         tick();
      end
      chk("relock", 16'(locked), 16'h1);
   endtask

   initial begin
      trx_rst = 1'b1; rx_reset_done = 1'b0; err_clr = 1'b0;
      good_word();
      tick(); tick();
      chk("rst_locked", 16'(locked), 16'h0);
      chk("rst_err", 16'(err), 16'h0);
      chk("rst_err_cnt", 16'(err_cnt), 16'h0);
      chk("rst_code_cnt", 16'(code_err_cnt), 16'h0);

      // WAIT -> HUNT, then first lock after 8 good words
      trx_rst = 1'b0; rx_reset_done = 1'b1;
      tick();
      chk("hunt_entry_locked", 16'(locked), 16'h0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("lock1_w%0d", i), 16'(locked), (i == 8) ? 16'h1 : 16'h0);
      end
      chk("lock1_err_cnt", 16'(err_cnt), 16'h0);

      // bad,bad,bad,good,bad while locked
      for (int i = 0; i < 5; i++) begin
         if (i == 3) good_word(); else bad_word();
         tick();
         chk($sformatf("bbbgb_err%0d", i), 16'(err), (i == 3) ? 16'h0 : 16'h1);
      end
      chk("bbbgb_err_cnt", 16'(err_cnt), 16'h4);
      chk("bbbgb_locked", 16'(locked), 16'h1);

      // clear coincident with a bad word: clear wins, pulse still seen
      err_clr = 1'b1; bad_word();
      tick();
      err_clr = 1'b0;
      chk("clr_err_cnt", 16'(err_cnt), 16'h0);
      chk("clr_err", 16'(err), 16'h1);
      chk("clr_locked", 16'(locked), 16'h1);

      // good resets the bad run; then 4 bad words drop lock
      good_word(); tick();
      for (int i = 1; i <= 4; i++) begin
         bad_word(); tick();
         chk($sformatf("unlock_b%0d", i), 16'(locked), (i == 4) ? 16'h0 : 16'h1);
      end
      chk("unlock_last_err", 16'(err), 16'h1);
      chk("unlock_err_cnt", 16'(err_cnt), 16'h4);

      // in HUNT: code error counted, no err pulse
      bad_word(); rx_not_in_table = 8'h04;
      tick();
      chk("hunt_err", 16'(err), 16'h0);
      chk("hunt_code_cnt", 16'(code_err_cnt), 16'h1);
      chk("hunt_err_cnt", 16'(err_cnt), 16'h4);

      // 7 good, 1 bad, 8 good: lock only at the very end, no err pulses
      for (int i = 1; i <= 16; i++) begin
         if (i == 8) bad_word(); else good_word();
         tick();
         chk($sformatf("hunt_break_err%0d", i), 16'(err), 16'h0);
         chk($sformatf("hunt_break_lock%0d", i), 16'(locked), (i == 16) ? 16'h1 : 16'h0);
      end

      // five runs of 4 bad words with re-lock between: counter saturates at 15
      exp_err = 4;
      for (int r = 1; r <= 5; r++) begin
         for (int i = 0; i < 4; i++) begin
            bad_word(); tick();
         end
         exp_err = (exp_err + 4 > 15) ? 15 : exp_err + 4;
         chk($sformatf("sat_run%0d_cnt", r), 16'(err_cnt), 16'(exp_err));
         chk($sformatf("sat_run%0d_locked", r), 16'(locked), 16'h0);
         relock();
      end

      // disparity error while locked counts as both kinds of error
      good_word(); rx_disp_err = 8'h80;
      tick();
      chk("lock_disp_err", 16'(err), 16'h1);
      chk("lock_disp_cnt", 16'(err_cnt), 16'hF);
      chk("lock_disp_code", 16'(code_err_cnt), 16'h2);

      // drop reset-done: WAIT, counters held, code errors ignored in WAIT
      good_word(); tick();
      rx_reset_done = 1'b0;
      tick();
      chk("drop_locked", 16'(locked), 16'h0);
      chk("drop_err_cnt", 16'(err_cnt), 16'hF);
      chk("drop_code_cnt", 16'(code_err_cnt), 16'h2);
      bad_word(); rx_not_in_table = 8'hFF;
      tick();
      chk("wait_code_cnt", 16'(code_err_cnt), 16'h2);
      chk("wait_err", 16'(err), 16'h0);

      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("wait_clr_err_cnt", 16'(err_cnt), 16'h0);
      chk("wait_clr_code_cnt", 16'(code_err_cnt), 16'h0);

      // lock, take an error, then one-cycle reset mid-lock
      rx_reset_done = 1'b1; good_word(); tick();
      relock();
      bad_word(); rx_disp_err = 8'h01; tick();
      chk("pre_rst_err_cnt", 16'(err_cnt), 16'h1);
      trx_rst = 1'b1; tick();
      chk("pulse_rst_locked", 16'(locked), 16'h0);
      chk("pulse_rst_err", 16'(err), 16'h0);
      chk("pulse_rst_err_cnt", 16'(err_cnt), 16'h0);
      chk("pulse_rst_code_cnt", 16'(code_err_cnt), 16'h0);
      trx_rst = 1'b0; good_word(); tick();
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("post_rst_w%0d", i), 16'(locked), (i == 8) ? 16'h1 : 16'h0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
